io_bus_arbiter: RTL and testbench
=================================

Name: io_bus_arbiter

Overview:
- Shares the single processor IO bus (address, write value, read value, strobes, data size) between two masters: master 0 is the Risc32 core, master 1 is a debug/DMA master.
- Sits between the masters and the board IO decode (SW/BTN/LED registers).
- Sequences each access as a fixed multi-cycle transaction with a ready handshake.
- Grants round-robin when both masters request.

Parameters:
- ADDR_W, 32, width of io address.
- DATA_W, 32, width of io read and write values.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_address  in  ADDR_W  master 0 address
- m0_write_value  in  DATA_W  master 0 write data
- m0_write_en  in  1  master 0 write request
- m0_read_en  in  1  master 0 read request
- m0_data_size  in  3  master 0 access size code
- m0_read_value  out  DATA_W  master 0 returned read data
- m0_ready  out  1  one-cycle completion pulse to master 0
- m1_*  same seven ports as m0_*, for master 1
- io_address  out  ADDR_W  shared bus address
- io_write_value  out  DATA_W  shared bus write data
- io_write_en  out  1  shared bus write strobe
- io_read_en  out  1  shared bus read strobe
- io_data_size  out  3  shared bus size code
- io_read_value  in  DATA_W  device read data, valid the cycle after io_read_en (device registers it)

Behaviour:
- Clock is clk. Reset is synchronous and active-high.
- Reset values: state IDLE; all io_* outputs 0; m0/m1_ready 0; m0/m1_read_value 0; last_grant = 1, so master 0 wins the first contention.
- A master requests when its read_en or write_en is high. The master holds address, data, size and strobes stable until it sees its ready pulse.
- FSM states:
  - IDLE: no request -> stay. Requests present -> select winner, latch its address, data, size and operation; go to ISSUE.
  - ISSUE (1 cycle): drive the latched values on io_*, with exactly one strobe high. Write -> ACK. Read -> WAIT.
  - WAIT (1 cycle): strobes 0; io_read_value is valid; capture it into the winner's m*_read_value. Go to ACK.
  - ACK (1 cycle): winner's m*_ready = 1. All requests are ignored this cycle. Go to IDLE.
- Latency, counted from request seen in IDLE at cycle 0:
  - Write: io_write_en at cycle 1, ready at cycle 2.
  - Read: io_read_en at cycle 1, data captured at end of cycle 2, ready and valid data at cycle 3.
  - Back-to-back throughput is one transaction per 3 (write) or 4 (read) cycles.
- Arbitration:
  - Single requester -> it wins.
  - Both requesting -> the master not equal to last_grant wins.
  - last_grant updates on entry to ISSUE.
- Both read_en and write_en high on one master: treated as a write only; no read strobe is issued. m*_read_value is unchanged.
- m*_read_value holds its last captured value until that master's next completed read. It is not cleared by writes or by the other master's reads.
- io_address, io_write_value and io_data_size are 0 outside ISSUE, so the LED decode never sees stale addresses.
- Loser's request stays pending and is granted in the next IDLE.
- Reset asserted in any state -> next cycle is IDLE with reset values. An in-flight transaction is dropped with no ready pulse. Masters must re-issue.
- A request that drops before ready is still completed; the bus access occurs regardless.

Decomposition:
- Shared package io_bus_pkg contains:
  - state enum IDLE/ISSUE/WAIT/ACK
  - master id constants MST_CPU=0, MST_DBG=1
  - data_size encodings (byte/half/word)
- Sub-module rr_arbiter2: a two-requester round-robin picker.
  - Inputs: req[1:0], last_grant, clk, reset.
  - Outputs: grant index and grant valid.
  - Purely combinational pick; the registered last_grant lives in io_bus_arbiter.

Test Plan:
- Master 0 writes 0x0000_A5A5 to address 4; master 1 idle -> io_write_en high for exactly one cycle with io_address=4 and io_write_value=0xA5A5; m0_ready pulses at cycle 2; m1_ready stays 0.
- Master 1 reads address 1 while the device model returns 0x0000_1234 the cycle after io_read_en -> m1_read_value=0x1234 and m1_ready at cycle 3; m0_read_value unchanged.
- Both masters request from reset: m0 reads address 2, m1 writes 0xFFFF to address 4 -> m0 is served first, then m1 is issued in the next IDLE; the grant order is 0,1,0,1 while both keep requesting.
- m0 asserts read_en and write_en together at address 4 with data 0x0F0F -> only io_write_en fires; io_read_en stays 0; m0_read_value is unchanged.
- Assert reset during WAIT of an m1 read -> the next cycle shows all outputs 0 and state IDLE; no m1_ready; m1's re-issued read then completes normally with m1 granted first (last_grant=1 after reset favours m0 only if both request).
- After a read returns 0xDEAD, m0 performs a write -> m0_read_value still 0xDEAD; io_address returns to 0 after ISSUE.

Source files
------------

// File: rtl/io_bus_pkg.sv
// io_bus_pkg
//   Shared types and constants for the processor IO bus arbiter.
//   - state_t   : transaction sequencer states
//   - MST_*     : master identifiers (also the grant index values)
//   - SIZE_*    : io data_size encodings carried on m*_data_size / io_data_size
package io_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } state_t;

   localparam logic MST_CPU = 1'b0;
   localparam logic MST_DBG = 1'b1;

   localparam logic [2:0] SIZE_BYTE = 3'd0;
   localparam logic [2:0] SIZE_HALF = 3'd1;
   localparam logic [2:0] SIZE_WORD = 3'd2;

   // A master is requesting whenever either strobe is raised.
   function automatic logic is_request(input logic rd_en, input logic wr_en);
      return rd_en | wr_en;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Two-requester round-robin picker. Purely combinational; the caller owns
//   the registered last_grant.
//   Ports:
//     clk, reset   : clock / synchronous active-high reset (reset masks the grant)
//     req[1:0]     : request per master (bit index = master id)
//     last_grant   : master granted most recently
//     grant_idx    : winning master id
//     grant_valid  : at least one request present and not in reset
module rr_arbiter2
   import io_bus_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant_idx,
   output logic       grant_valid
);

   // The pick has no state of its own; the clock is only part of the port set.
   logic unused_clk;
   assign unused_clk = clk;

   always_comb begin
      grant_idx   = MST_CPU;
      grant_valid = 1'b0;
      if (!reset) begin
         grant_valid = |req;
         case (req)
            2'b01:   grant_idx = MST_CPU;
            2'b10:   grant_idx = MST_DBG;
            // Contention: whoever did not win last time goes now.
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = MST_CPU;
         endcase
      end
   end

endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
//   Shares the processor IO bus between master 0 (Risc32 core) and master 1
//   (debug/DMA). Each access runs as a fixed sequence IDLE -> ISSUE ->
//   [WAIT for reads] -> ACK, and the winner gets a one-cycle ready pulse.
//   Ports:
//     clk, reset                 : clock, synchronous active-high reset
//     m{0,1}_address/write_value : master request payload (held until ready)
//     m{0,1}_write_en/read_en    : master strobes (both high = write only)
//     m{0,1}_data_size           : master size code
//     m{0,1}_read_value          : last read data returned to that master
//     m{0,1}_ready               : completion pulse
//     io_*                       : shared bus towards the board IO decode;
//                                  io_read_value arrives the cycle after io_read_en
module io_bus_arbiter
   import io_bus_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,

   input  logic [ADDR_W-1:0] m0_address,
   input  logic [DATA_W-1:0] m0_write_value,
   input  logic              m0_write_en,
   input  logic              m0_read_en,
   input  logic [2:0]        m0_data_size,
   output logic [DATA_W-1:0] m0_read_value,
   output logic              m0_ready,

   input  logic [ADDR_W-1:0] m1_address,
   input  logic [DATA_W-1:0] m1_write_value,
   input  logic              m1_write_en,
   input  logic              m1_read_en,
   input  logic [2:0]        m1_data_size,
   output logic [DATA_W-1:0] m1_read_value,
   output logic              m1_ready,

   output logic [ADDR_W-1:0] io_address,
   output logic [DATA_W-1:0] io_write_value,
   output logic              io_write_en,
   output logic              io_read_en,
   output logic [2:0]        io_data_size,
   input  logic [DATA_W-1:0] io_read_value
);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              winner_q, winner_d;
   logic              is_write_q, is_write_d;

   // The io_* registers double as the latched request: they are loaded on
   // the IDLE->ISSUE edge and zeroed on the way out of ISSUE.
   logic [ADDR_W-1:0] io_address_q, io_address_d;
   logic [DATA_W-1:0] io_write_value_q, io_write_value_d;
   logic              io_write_en_q, io_write_en_d;
   logic              io_read_en_q, io_read_en_d;
   logic [2:0]        io_data_size_q, io_data_size_d;

   logic [1:0]        ready_q, ready_d;
   logic [DATA_W-1:0] rd_val_q [2];
   logic [DATA_W-1:0] rd_val_d [2];

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
   logic [1:0] req;
   logic       grant_idx;
   logic       grant_valid;

   assign req[0] = is_request(m0_read_en, m0_write_en);
   assign req[1] = is_request(m1_read_en, m1_write_en);

   rr_arbiter2 u_rr (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .last_grant  (last_grant_q),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // Payload of whichever master the picker selected.
   logic [ADDR_W-1:0] sel_address;
   logic [DATA_W-1:0] sel_write_value;
   logic              sel_write_en;
   logic              sel_read_en;
   logic [2:0]        sel_data_size;

   always_comb begin
      if (grant_idx == MST_DBG) begin
         sel_address     = m1_address;
         sel_write_value = m1_write_value;
         sel_write_en    = m1_write_en;
         sel_read_en     = m1_read_en;
         sel_data_size   = m1_data_size;
      end else begin
         sel_address     = m0_address;
         sel_write_value = m0_write_value;
         sel_write_en    = m0_write_en;
         sel_read_en     = m0_read_en;
         sel_data_size   = m0_data_size;
      end
   end

   // ------------------------------------------------------------------
   // Next-state / outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_d          = state_q;
      last_grant_d     = last_grant_q;
      winner_d         = winner_q;
      is_write_d       = is_write_q;
      // Bus is quiet by default so the decode never sees a stale address.
      io_address_d     = '0;
      io_write_value_d = '0;
      io_write_en_d    = 1'b0;
      io_read_en_d     = 1'b0;
      io_data_size_d   = '0;
      ready_d          = 2'b00;
      rd_val_d         = rd_val_q;

      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               winner_d         = grant_idx;
               last_grant_d     = grant_idx;
               // A simultaneous read+write is a plain write.
               is_write_d       = sel_write_en;
               io_address_d     = sel_address;
               io_write_value_d = sel_write_value;
               io_data_size_d   = sel_data_size;
               io_write_en_d    = sel_write_en;
               io_read_en_d     = sel_read_en & ~sel_write_en;
               state_d          = ISSUE;
            end
         end

         ISSUE: begin
            if (is_write_q) begin
               // ready is registered, so raising it here lands it in ACK.
               ready_d[winner_q] = 1'b1;
               state_d           = ACK;
            end else begin
               state_d = WAIT;
            end
         end

         WAIT: begin
            // Device registered the read strobe; its data is on the bus now.
            rd_val_d[winner_q] = io_read_value;
            ready_d[winner_q]  = 1'b1;
            state_d            = ACK;
         end

         ACK: begin
            // Requests are deliberately not looked at here.
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= IDLE;
         last_grant_q     <= MST_DBG;   // master 0 wins the first contention
         winner_q         <= MST_CPU;
         is_write_q       <= 1'b0;
         io_address_q     <= '0;
         io_write_value_q <= '0;
         io_write_en_q    <= 1'b0;
         io_read_en_q     <= 1'b0;
         io_data_size_q   <= '0;
         ready_q          <= 2'b00;
         rd_val_q[0]      <= '0;
         rd_val_q[1]      <= '0;
      end else begin
         state_q          <= state_d;
         last_grant_q     <= last_grant_d;
         winner_q         <= winner_d;
         is_write_q       <= is_write_d;
         io_address_q     <= io_address_d;
         io_write_value_q <= io_write_value_d;
         io_write_en_q    <= io_write_en_d;
         io_read_en_q     <= io_read_en_d;
         io_data_size_q   <= io_data_size_d;
         ready_q          <= ready_d;
         rd_val_q[0]      <= rd_val_d[0];
         rd_val_q[1]      <= rd_val_d[1];
      end
   end

   assign io_address     = io_address_q;
   assign io_write_value = io_write_value_q;
   assign io_write_en    = io_write_en_q;
   assign io_read_en     = io_read_en_q;
   assign io_data_size   = io_data_size_q;

   assign m0_ready       = ready_q[0];
   assign m1_ready       = ready_q[1];
   assign m0_read_value  = rd_val_q[0];
   assign m1_read_value  = rd_val_q[1];

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter
//   Randomized two-master bench for io_bus_arbiter with a transaction-level
//   reference model: each grant is a record with a start cycle, and the
//   expected bus/ready/read-data activity is derived from fixed offsets.
module tb_io_bus_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int NCYC   = 3000;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] m0_address, m1_address;
   logic [DATA_W-1:0] m0_write_value, m1_write_value;
   logic              m0_write_en, m1_write_en, m0_read_en, m1_read_en;
   logic [2:0]        m0_data_size, m1_data_size;
   logic [DATA_W-1:0] m0_read_value, m1_read_value;
   logic              m0_ready, m1_ready;
   logic [ADDR_W-1:0] io_address;
   logic [DATA_W-1:0] io_write_value;
   logic              io_write_en, io_read_en;
   logic [2:0]        io_data_size;
   logic [DATA_W-1:0] io_read_value;

   always #5 clk = ~clk;

   io_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .m0_address     (m0_address),
      .m0_write_value (m0_write_value),
      .m0_write_en    (m0_write_en),
      .m0_read_en     (m0_read_en),
      .m0_data_size   (m0_data_size),
      .m0_read_value  (m0_read_value),
      .m0_ready       (m0_ready),
      .m1_address     (m1_address),
      .m1_write_value (m1_write_value),
      .m1_write_en    (m1_write_en),
      .m1_read_en     (m1_read_en),
      .m1_data_size   (m1_data_size),
      .m1_read_value  (m1_read_value),
      .m1_ready       (m1_ready),
      .io_address     (io_address),
      .io_write_value (io_write_value),
      .io_write_en    (io_write_en),
      .io_read_en     (io_read_en),
      .io_data_size   (io_data_size),
      .io_read_value  (io_read_value)
   );

   // Device: registers the read; returns junk on cycles without a read.
   logic [31:0] mem [16];
   always @(posedge clk)
      io_read_value <= io_read_en ? mem[io_address[3:0]] : $urandom;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  size;
      int          not_before;
   } req_t;

   req_t dq0[$];
   req_t dq1[$];

   // Model state
   req_t        cur [2];
   bit          pend [2];
   bit          granted [2];
   logic [31:0] exp_rv [2];
   bit          lg;
   bit          tx_active;
   int          tx_start, tx_end, tx_m;
   bit          tx_wr;
   logic [31:0] tx_addr, tx_data;
   logic [2:0]  tx_size;
   bit          rst_prev, rst_now;

   function automatic req_t rand_req();
      req_t r;
      int   op;
      op     = $urandom_range(0, 3);
      r.rd   = (op == 0) || (op == 2) || (op == 3);
      r.wr   = (op == 1) || (op == 2);
      r.addr = $urandom;
      r.data = $urandom;
      r.size = 3'($urandom_range(0, 2));
      r.not_before = 0;
      return r;
   endfunction

   function automatic req_t mk(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] data, input int nb);
      req_t r;
      r.rd = rd; r.wr = wr; r.addr = addr; r.data = data; r.size = 3'd2; r.not_before = nb;
      return r;
   endfunction

   task automatic gen(input int m, input int n);
      if (!pend[m] && !(tx_active && tx_m == m)) begin
         if (m == 0 && dq0.size() > 0) begin
            if (n >= dq0[0].not_before) begin cur[0] = dq0.pop_front(); pend[0] = 1; end
         end else if (m == 1 && dq1.size() > 0) begin
            if (n >= dq1[0].not_before) begin cur[1] = dq1.pop_front(); pend[1] = 1; end
         end else if ($urandom_range(0, 2) == 0) begin
            cur[m]  = rand_req();
            pend[m] = 1;
         end
      end else if (pend[m] && granted[m] && $urandom_range(0, 24) == 0) begin
         // Master gives up early; the access must still complete.
         pend[m]    = 0;
         granted[m] = 0;
      end
   endtask

   task automatic drive();
      m0_address     = pend[0] ? cur[0].addr : '0;
      m0_write_value = pend[0] ? cur[0].data : '0;
      m0_write_en    = pend[0] && cur[0].wr;
      m0_read_en     = pend[0] && cur[0].rd;
      m0_data_size   = pend[0] ? cur[0].size : '0;
      m1_address     = pend[1] ? cur[1].addr : '0;
      m1_write_value = pend[1] ? cur[1].data : '0;
      m1_write_en    = pend[1] && cur[1].wr;
      m1_read_en     = pend[1] && cur[1].rd;
      m1_data_size   = pend[1] ? cur[1].size : '0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      mem[1] = 32'h0000_1234;
      mem[2] = 32'h0000_DEAD;

      dq0.push_back(mk(0, 1, 32'd4, 32'h0000_A5A5, 0));
      dq0.push_back(mk(1, 0, 32'd2, 32'h0,         0));
      dq0.push_back(mk(1, 1, 32'd4, 32'h0000_0F0F, 0));
      dq0.push_back(mk(0, 1, 32'd8, 32'h0000_1111, 0));
      dq1.push_back(mk(1, 0, 32'd1, 32'h0,         4));
      dq1.push_back(mk(0, 1, 32'd4, 32'h0000_FFFF, 4));

      pend      = '{0, 0};
      granted   = '{0, 0};
      tx_active = 0;
      tx_start  = 0; tx_end = 0; tx_m = 0; tx_wr = 0;
      tx_addr   = '0; tx_data = '0; tx_size = '0;
      rst_prev  = 1;
      reset     = 1'b1;
      drive();
      repeat (2) @(posedge clk);

      for (int n = 0; n < NCYC; n++) begin
         bit issue, rdy;
         @(posedge clk);
         #1;
         if (rst_prev) begin
            tx_active = 0;
            lg        = 1;
            exp_rv    = '{32'h0, 32'h0};
            granted   = '{0, 0};
         end
         if (tx_active && !tx_wr && n == tx_start + 3)
            exp_rv[tx_m] = mem[tx_addr[3:0]];

         issue = tx_active && (n == tx_start + 1);
         rdy   = tx_active && (n == tx_start + (tx_wr ? 2 : 3));
         check("io_address",     io_address,           issue ? tx_addr : 32'h0);
         check("io_write_value", io_write_value,       issue ? tx_data : 32'h0);
         check("io_data_size",   32'(io_data_size),    issue ? 32'(tx_size) : 32'h0);
         check("io_write_en",    32'(io_write_en),     32'(issue && tx_wr));
         check("io_read_en",     32'(io_read_en),      32'(issue && !tx_wr));
         check("m0_ready",       32'(m0_ready),        32'(rdy && tx_m == 0));
         check("m1_ready",       32'(m1_ready),        32'(rdy && tx_m == 1));
         check("m0_read_value",  m0_read_value,        exp_rv[0]);
         check("m1_read_value",  m1_read_value,        exp_rv[1]);

         if (rdy) begin
            $display("txn cyc=%0d m%0d %s addr=%08h wdata=%08h rdata=%08h",
                     n, tx_m, tx_wr ? "WR" : "RD", tx_addr, tx_data, exp_rv[tx_m]);
            if (granted[tx_m]) begin
               pend[tx_m]    = 0;
               granted[tx_m] = 0;
            end
         end
         if (tx_active && n >= tx_end) tx_active = 0;

         gen(0, n);
         gen(1, n);
         rst_now = (n > 40) && (n < NCYC - 10) && ($urandom_range(0, 49) == 0);
         reset   = rst_now;
         drive();

         if (!rst_now && !tx_active && (pend[0] || pend[1])) begin
            int w;
            if (pend[0] && pend[1]) w = lg ? 0 : 1;
            else                    w = pend[0] ? 0 : 1;
            tx_m      = w;
            tx_wr     = cur[w].wr;
            tx_addr   = cur[w].addr;
            tx_data   = cur[w].data;
            tx_size   = cur[w].size;
            tx_start  = n;
            tx_end    = n + (tx_wr ? 3 : 4);
            tx_active = 1;
            lg        = w[0];
            granted[w] = 1;
         end
         rst_prev = rst_now;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
